// File: rtl/selecteur_lanceur_de.sv
// Dice selector / roller front end.
// Conditions two raw push-buttons, steps the die type, runs the roll
// counter while btn_roll is held and registers the BCD result on release.
module selecteur_lanceur_de (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_select,
  input  logic       btn_roll,
  output logic [2:0] de_value,
  output logic [3:0] result_hundreds,
  output logic [3:0] result_tens,
  output logic [3:0] result_units,
  output logic       result_valid,
  output logic       rolling
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SHOW    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       sel_s1, sel_s2, sel_prev;
  logic       roll_s1, roll_s2, roll_prev;
  logic       sel_rise, roll_rise, roll_fall;

  logic [6:0] spin;
  logic [6:0] spin_max;
  logic [11:0] spin_bcd;

  logic       start_roll;
  logic       step_die;
  logic       capture;

  // Largest face of each die code; the spin counter wraps back to 1 after it.
  function automatic logic [6:0] max_of(input logic [2:0] code);
    logic [6:0] m;
    case (code)
      3'd0:    m = 7'd4;
      3'd1:    m = 7'd6;
      3'd2:    m = 7'd8;
      3'd3:    m = 7'd10;
      3'd4:    m = 7'd12;
      3'd5:    m = 7'd20;
      3'd6:    m = 7'd30;
      default: m = 7'd100;
    endcase
    return m;
  endfunction

  // Binary 1..100 to three BCD digits {hundreds, tens, units}.
  function automatic logic [11:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] h, t, u;
    h   = (v >= 7'd100) ? 4'd1 : 4'd0;
    rem = (v >= 7'd100) ? (v - 7'd100) : v;
    t   = 4'(rem / 7'd10);
    u   = 4'(rem % 7'd10);
    return {h, t, u};
  endfunction

  // Two-flop synchronizers followed by a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_s1    <= 1'b0;
      sel_s2    <= 1'b0;
      sel_prev  <= 1'b0;
      roll_s1   <= 1'b0;
      roll_s2   <= 1'b0;
      roll_prev <= 1'b0;
    end else begin
      sel_s1    <= btn_select;
      sel_s2    <= sel_s1;
      sel_prev  <= sel_s2;
      roll_s1   <= btn_roll;
      roll_s2   <= roll_s1;
      roll_prev <= roll_s2;
    end
  end

  assign sel_rise  = sel_s2 & ~sel_prev;
  assign roll_rise = roll_s2 & ~roll_prev;
  assign roll_fall = ~roll_s2 & roll_prev;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: a roll press wins over a select press in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHOW: begin
        if (roll_rise)     state_next = ROLLING;
        else if (sel_rise) state_next = IDLE;
      end
      ROLLING: begin
        if (roll_fall) state_next = SHOW;
      end
      default: state_next = IDLE;
    endcase
  end

  // State outputs and datapath strobes.
  always_comb begin
    rolling    = 1'b0;
    start_roll = 1'b0;
    step_die   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, SHOW: begin
        start_roll = roll_rise;
        step_die   = sel_rise & ~roll_rise;
      end
      ROLLING: begin
        rolling = 1'b1;
        capture = roll_fall;
      end
      default: ;
    endcase
  end

  assign spin_max = max_of(de_value);
  assign spin_bcd = to_bcd(spin);

  // Die selection, spin counter and captured result.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_value        <= 3'd0;
      spin            <= 7'd1;
      result_hundreds <= 4'd0;
      result_tens     <= 4'd0;
      result_units    <= 4'd0;
      result_valid    <= 1'b0;
    end else begin
      if (step_die) de_value <= de_value + 3'd1;

      if (start_roll)
        spin <= 7'd1;
      else if (rolling && !capture)
        spin <= (spin == spin_max) ? 7'd1 : spin + 7'd1;

      if (capture) begin
        {result_hundreds, result_tens, result_units} <= spin_bcd;
        result_valid <= 1'b1;
      end else if (start_roll || step_die) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule
